sisc_ctrl_ws: RTL and testbench

- Parametrised multi-cycle SISC control FSM.
- Generalises the existing fixed 7-state controller in three ways:
  - configurable opcode and condition-code widths;
  - a req/ack memory handshake with wait states and timeout on instruction fetch and data access;
  - a sticky HALT/ERR state and an instruction-retired counter.
- Sits between the IR/status register and the datapath muxes, register file, PC and memories.

---
 rtl/sisc_pkg.sv | 63 ++++++
 rtl/sisc_ctrl_ws_if.sv | 13 +
 rtl/sisc_wait_timer.sv | 31 +++
 rtl/sisc_ctrl_ws.sv | 196 +++++++++++++++++++
 tb/tb_sisc_ctrl_ws.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared constants, encodings and opcode decode for the SISC controller
// Purpose: opcode values, FSM state encoding, ALU/write-back select encodings,
//          default immediate addressing mode and a helper that classifies opcodes.
// Ports:   none (package).
package sisc_pkg;

  localparam int OP_NOOP = 0;
  localparam int OP_LOD  = 1;
  localparam int OP_STR  = 2;
  localparam int OP_SWP  = 3;
  localparam int OP_BRA  = 4;
  localparam int OP_BRR  = 5;
  localparam int OP_BNE  = 6;
  localparam int OP_BNR  = 7;
  localparam int OP_ALU  = 8;
  localparam int OP_HLT  = 15;

  localparam int AM_IMM_DEF = 8;

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_SWPA = 2'd2;
  localparam logic [1:0] WB_SWPB = 2'd3;

  localparam logic [1:0] ALU_REG  = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_AREG = 2'b10;
  localparam logic [1:0] ALU_AIMM = 2'b11;

  typedef enum logic [3:0] {
    K_NOOP, K_LOD, K_STR, K_SWP, K_BRA, K_BRR, K_BNE, K_BNR, K_ALU, K_HLT
  } op_kind_t;

  // Unassigned opcodes fold into NOOP so the FSM never needs an illegal-op path.
  function automatic op_kind_t decode_op(input logic [31:0] op);
    op_kind_t k;
    case (op)
      32'(OP_LOD): k = K_LOD;
      32'(OP_STR): k = K_STR;
      32'(OP_SWP): k = K_SWP;
      32'(OP_BRA): k = K_BRA;
      32'(OP_BRR): k = K_BRR;
      32'(OP_BNE): k = K_BNE;
      32'(OP_BNR): k = K_BNR;
      32'(OP_ALU): k = K_ALU;
      32'(OP_HLT): k = K_HLT;
      default:     k = K_NOOP;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sisc_ctrl_ws_if.sv
// rtl/sisc_ctrl_ws_if.sv - memory request/acknowledge bundle between controller and memories
// Purpose: groups the memory handshake and data-memory strobes.
// Ports:   mem_req, dm_we, dm_re (controller -> memory); mem_ack (memory -> controller).
//          master = controller side, slave = memory side.
interface sisc_ctrl_ws_if;
  logic mem_req;
  logic mem_ack;
  logic dm_we;
  logic dm_re;

  modport master (output mem_req, output dm_we, output dm_re, input mem_ack);
  modport slave  (input mem_req, input dm_we, input dm_re, output mem_ack);
endinterface

// File: rtl/sisc_wait_timer.sv
// rtl/sisc_wait_timer.sv - wait-state counter with timeout flag
// Purpose: counts ack-less cycles of a pending request; cleared whenever the
//          owning FSM changes state; flags when the tolerated wait is used up.
// Ports:   clk, rst (sync, active-high), clr (owner changes state),
//          inc (one more ack-less cycle), expired (count has reached MAX_WAIT).
module sisc_wait_timer #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign expired = (wait_cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/sisc_ctrl_ws.sv
// rtl/sisc_ctrl_ws.sv - multi-cycle SISC control FSM with memory wait states and timeout
// Purpose: sequences fetch/decode/execute/mem/writeback, drives datapath selects,
//          stalls on memory acknowledge, traps to ERR on timeout, HALT on HLT,
//          and counts retired instructions.
// Ports:   clk, rst_f (sync, active-high); opcode, mm, stat (IR fields, status);
//          mem (memory handshake, master); ir_load, pc_write, pc_sel, br_sel, pc_rst,
//          rb_sel, rf_we, alu_op, wb_sel, swap_ctrl (datapath controls);
//          halted, err (sticky terminal states); retired (wrapping instruction count).
module sisc_ctrl_ws
  import sisc_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int CC_W     = 4,
  parameter int AM_IMM   = AM_IMM_DEF,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [OP_W-1:0]   opcode,
  input  logic [CC_W-1:0]   mm,
  input  logic [CC_W-1:0]   stat,
  sisc_ctrl_ws_if.master    mem,
  output logic              ir_load,
  output logic              pc_write,
  output logic              pc_sel,
  output logic              br_sel,
  output logic              pc_rst,
  output logic              rb_sel,
  output logic              rf_we,
  output logic [1:0]        alu_op,
  output logic [1:0]        wb_sel,
  output logic              swap_ctrl,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  state_t          state, next_state;
  logic [OP_W-1:0] op_q;
  logic [CC_W-1:0] mm_q;
  logic            retire, wait_inc, wait_expired, taken;
  logic            mem_req_c, dm_we_c, dm_re_c;
  op_kind_t        kind_in, kind_q;
  logic            cond, imm_q;

  // DECODE acts on the live IR; every later state uses the latched copy.
  assign kind_in = decode_op(32'(opcode));
  assign kind_q  = decode_op(32'(op_q));
  assign cond    = |(stat & mm);
  assign imm_q   = (mm_q == CC_W'(AM_IMM));

  sisc_wait_timer #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) u_wait (
    .clk     (clk),
    .rst     (rst_f),
    .clr     (next_state != state),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    wait_inc   = 1'b0;
    taken      = 1'b0;
    mem_req_c  = 1'b0;
    dm_we_c    = 1'b0;
    dm_re_c    = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    br_sel     = 1'b0;
    pc_rst     = 1'b0;
    rb_sel     = 1'b0;
    rf_we      = 1'b0;
    alu_op     = ALU_REG;
    wb_sel     = WB_ALU;
    swap_ctrl  = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;
    case (state)
      S_START: begin
        pc_rst     = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        // A late ack on the last tolerated cycle still completes the fetch.
        if (mem.mem_ack) begin
          ir_load    = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (wait_expired) begin
          next_state = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        case (kind_in)
          K_BRA, K_BRR, K_BNE, K_BNR: begin
            taken      = (kind_in == K_BRA || kind_in == K_BRR) ? cond : !cond;
            pc_write   = taken;
            pc_sel     = taken;
            br_sel     = taken && (kind_in == K_BRA || kind_in == K_BNE);
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          K_HLT:        next_state = S_HALT;
          K_LOD, K_ALU: next_state = S_EXECUTE;
          K_STR, K_SWP: begin
            rb_sel     = 1'b1;
            next_state = S_EXECUTE;
          end
          default: begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_EXECUTE: begin
        case (kind_q)
          K_ALU: begin
            alu_op     = imm_q ? ALU_IMM : ALU_REG;
            next_state = S_WRITEBACK;
          end
          K_LOD, K_STR: begin
            alu_op     = imm_q ? ALU_AIMM : ALU_AREG;
            next_state = S_MEM;
          end
          K_SWP: begin
            rb_sel     = 1'b1;
            swap_ctrl  = 1'b1;
            rf_we      = 1'b1;
            wb_sel     = WB_SWPA;
            next_state = S_WRITEBACK;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        dm_we_c   = (kind_q == K_STR);
        dm_re_c   = (kind_q == K_LOD);
        // Address computation stays selected so the memory sees a stable address.
        alu_op    = imm_q ? ALU_AIMM : ALU_AREG;
        if (mem.mem_ack) begin
          if (kind_q == K_STR) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WRITEBACK;
          end
        end else if (wait_expired) begin
          next_state = S_ERR;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WRITEBACK: begin
        rf_we      = 1'b1;
        wb_sel     = (kind_q == K_SWP) ? WB_SWPB :
                     (kind_q == K_LOD) ? WB_MEM  : WB_ALU;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   err    = 1'b1;
      default: next_state = S_ERR;
    endcase
  end

  assign mem.mem_req = mem_req_c;
  assign mem.dm_we   = dm_we_c;
  assign mem.dm_re   = dm_re_c;

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state   <= S_START;
      op_q    <= '0;
      mm_q    <= '0;
      retired <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q <= opcode;
        mm_q <= mm;
      end
      if (retire) begin
        retired <= retired + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sisc_ctrl_ws.sv
// tb/tb_sisc_ctrl_ws.sv - self-checking bench for sisc_ctrl_ws
module tb_sisc_ctrl_ws;

  localparam int CNT_W    = 8;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_f;
  logic [3:0]       opcode, mm, stat;
  logic             ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel, rf_we;
  logic [1:0]       alu_op, wb_sel;
  logic             swap_ctrl, halted, err;
  logic [CNT_W-1:0] retired;

  sisc_ctrl_ws_if mem ();

  sisc_ctrl_ws #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .opcode    (opcode),
    .mm        (mm),
    .stat      (stat),
    .mem       (mem),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .pc_rst    (pc_rst),
    .rb_sel    (rb_sel),
    .rf_we     (rf_we),
    .alu_op    (alu_op),
    .wb_sel    (wb_sel),
    .swap_ctrl (swap_ctrl),
    .halted    (halted),
    .err       (err),
    .retired   (retired)
  );

  typedef struct packed {
    logic       mem_req, dm_we, dm_re, ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel, rf_we;
    logic [1:0] alu_op, wb_sel;
    logic       swap_ctrl, halted, err;
  } outs_t;

  typedef struct {
    logic [3:0]       op, mm, st;
    logic             ack;
    outs_t            exp;
    logic [CNT_W-1:0] ret;
    bit               dec;
  } cyc_t;

  typedef struct {
    logic [3:0] op, mm, st;
    logic       pw, ps, bs, rb;
    int         dret;
  } vec_t;

  cyc_t  q[$];
  int    total = 0;
  int    bad = 0;
  int    m_ret = 0;
  int    cyc_no = 0;
  outs_t dec_obs;
  vec_t  tbl[12];

  function automatic outs_t got_o();
    outs_t o;
    o.mem_req = mem.mem_req; o.dm_we = mem.dm_we; o.dm_re = mem.dm_re;
    o.ir_load = ir_load; o.pc_write = pc_write; o.pc_sel = pc_sel; o.br_sel = br_sel;
    o.pc_rst = pc_rst; o.rb_sel = rb_sel; o.rf_we = rf_we; o.alu_op = alu_op;
    o.wb_sel = wb_sel; o.swap_ctrl = swap_ctrl; o.halted = halted; o.err = err;
    return o;
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc_no, got, exp);
    end
  endtask

  task automatic add(input outs_t e, input logic [3:0] op, input logic [3:0] m,
                     input logic [3:0] st, input logic ack, input bit dec);
    cyc_t c;
    c.op = op; c.mm = m; c.st = st; c.ack = ack; c.exp = e;
    c.ret = CNT_W'(m_ret); c.dec = dec;
    q.push_back(c);
  endtask

  // Expected per-cycle trace of one instruction, written from the instruction's
  // semantics: fetch (fw ack-less cycles), decode, then the instruction's phases.
  task automatic build(input logic [3:0] op, input logic [3:0] m, input logic [3:0] st,
                       input int fw, input int mw);
    outs_t e;
    logic  imm, tk;
    imm = (m == 4'd8);
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_req = 1'b1;
      add(e, r4(), r4(), r4(), 1'b0, 0);
    end
    e = '0; e.mem_req = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
    add(e, r4(), r4(), r4(), 1'b1, 0);
    e = '0;
    case (op)
      4'd4, 4'd5, 4'd6, 4'd7: begin
        tk = (op < 4'd6) ? ((st & m) != 4'd0) : ((st & m) == 4'd0);
        e.pc_write = tk; e.pc_sel = tk; e.br_sel = tk && (op == 4'd4 || op == 4'd6);
        add(e, op, m, st, r1(), 1);
        m_ret++;
      end
      4'd15: begin
        add(e, op, m, st, r1(), 1);
        for (int i = 0; i < 3; i++) begin
          e = '0; e.halted = 1'b1;
          add(e, r4(), r4(), r4(), r1(), 0);
        end
      end
      4'd1, 4'd2, 4'd3, 4'd8: begin
        e.rb_sel = (op == 4'd2 || op == 4'd3);
        add(e, op, m, st, r1(), 1);
        e = '0;
        if (op == 4'd8) begin
          e.alu_op = {1'b0, imm};
          add(e, r4(), r4(), r4(), r1(), 0);
          e = '0; e.rf_we = 1'b1;
          add(e, r4(), r4(), r4(), r1(), 0);
          m_ret++;
        end else if (op == 4'd3) begin
          e.rb_sel = 1'b1; e.swap_ctrl = 1'b1; e.rf_we = 1'b1; e.wb_sel = 2'd2;
          add(e, r4(), r4(), r4(), r1(), 0);
          e = '0; e.rf_we = 1'b1; e.wb_sel = 2'd3;
          add(e, r4(), r4(), r4(), r1(), 0);
          m_ret++;
        end else begin
          e.alu_op = {1'b1, imm};
          add(e, r4(), r4(), r4(), r1(), 0);
          for (int i = 0; i <= mw; i++) begin
            e = '0; e.mem_req = 1'b1; e.dm_we = (op == 4'd2); e.dm_re = (op == 4'd1);
            e.alu_op = {1'b1, imm};
            add(e, r4(), r4(), r4(), (i == mw), 0);
          end
          if (op == 4'd1) begin
            e = '0; e.rf_we = 1'b1; e.wb_sel = 2'd1;
            add(e, r4(), r4(), r4(), r1(), 0);
          end
          m_ret++;
        end
      end
      default: begin
        add(e, op, m, st, r1(), 1);
        m_ret++;
      end
    endcase
  endtask

  task automatic run_q(input int n);
    int k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      cyc_t c;
      c = q.pop_front();
      opcode = c.op; mm = c.mm; stat = c.st; mem.mem_ack = c.ack;
      #2;
      chk("outs", 32'(got_o()), 32'(c.exp));
      chk("retired", 32'(retired), 32'(c.ret));
      if (c.dec) dec_obs = got_o();
      @(posedge clk); #1;
      k++; cyc_no++;
    end
  endtask

  task automatic do_reset();
    outs_t e;
    rst_f = 1'b1; mem.mem_ack = r1(); opcode = r4(); mm = r4(); stat = r4();
    @(posedge clk); #1;
    rst_f = 1'b0;
    q.delete();
    m_ret = 0;
    e = '0; e.pc_rst = 1'b1;
    add(e, r4(), r4(), r4(), r1(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc_no);
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    outs_t      e;
    rst_f = 1'b1; opcode = '0; mm = '0; stat = '0; mem.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //          op     mm     st     pw    ps    bs    rb    dret
    tbl[0]  = '{4'd8,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[1]  = '{4'd1,  4'd8,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[2]  = '{4'd2,  4'd3,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[3]  = '{4'd3,  4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[4]  = '{4'd4,  4'd2,  4'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[5]  = '{4'd4,  4'd2,  4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{4'd7,  4'd1,  4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[7]  = '{4'd6,  4'd1,  4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{4'd5,  4'd3,  4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[9]  = '{4'd15, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{4'd11, 4'd0,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[11] = '{4'd6,  4'd4,  4'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1};

    for (int i = 0; i < 12; i++) begin
      do_reset();
      build(tbl[i].op, tbl[i].mm, tbl[i].st, 0, 3);
      run_q(-1);
      chk("tbl_pc_write", 32'(dec_obs.pc_write), 32'(tbl[i].pw));
      chk("tbl_pc_sel", 32'(dec_obs.pc_sel), 32'(tbl[i].ps));
      chk("tbl_br_sel", 32'(dec_obs.br_sel), 32'(tbl[i].bs));
      chk("tbl_rb_sel", 32'(dec_obs.rb_sel), 32'(tbl[i].rb));
      chk("tbl_retired", 32'(retired), 32'(tbl[i].dret));
    end

    // Fetch never acknowledged: MAX_WAIT+1 request cycles, then sticky ERR.
    do_reset();
    for (int i = 0; i <= MAX_WAIT; i++) begin
      e = '0; e.mem_req = 1'b1;
      add(e, r4(), r4(), r4(), 1'b0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      e = '0; e.err = 1'b1;
      add(e, r4(), r4(), r4(), r1(), 0);
    end
    run_q(-1);
    do_reset();
    run_q(-1);

    // Ack arriving on the last tolerated cycle wins over timeout.
    do_reset();
    build(4'd8, 4'd0, 4'd0, MAX_WAIT, 0);
    build(4'd1, 4'd8, 4'd0, 0, MAX_WAIT);
    build(4'd2, 4'd0, 4'd0, MAX_WAIT, MAX_WAIT);
    run_q(-1);

    // Reset in the middle of a MEM wait.
    do_reset();
    build(4'd8, 4'd0, 4'd0, 0, 0);
    build(4'd1, 4'd0, 4'd0, 0, 8);
    run_q(12);
    chk("pre_reset_retired", 32'(retired), 32'd1);
    chk("pre_reset_mem_req", 32'(mem.mem_req), 32'd1);
    do_reset();
    run_q(-1);

    // Counter wrap past all-ones.
    do_reset();
    for (int i = 0; i < 260; i++) build(4'd0, r4(), r4(), $urandom_range(0, 1), 0);
    run_q(-1);
    chk("wrap_retired", 32'(retired), 32'd4);

    // Randomized instruction stream.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 14));
      build(op, ($urandom_range(0, 3) == 0) ? 4'd8 : r4(), r4(),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAX_WAIT) : $urandom_range(0, 2),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAX_WAIT) : $urandom_range(0, 3));
    end
    build(4'd15, r4(), r4(), 1, 0);
    run_q(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
